// File: rtl/mem_req_initiator.sv
// Core-side initiator for one shared-memory RAM port: issues a request, decodes the
// back packet, retries failed or timed-out attempts at rising priority, reports completion.
module mem_req_initiator #(
    parameter int CORE_ID         = 0,
    parameter int MAX_RETRY       = 3,
    parameter int RSP_TIMEOUT     = 8,
    parameter int CNT_W           = 16,
    parameter int LOCAL_ADDR_BITS = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int PRI_BITS        = 3,
    parameter int CORE_ID_BITS    = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        req_valid,
    output logic                                        req_ready,
    input  logic                                        req_we,
    input  logic [LOCAL_ADDR_BITS-1:0]                  req_addr,
    input  logic [DATA_WIDTH-1:0]                       req_wdata,
    input  logic [PRI_BITS-1:0]                         req_pri,
    output logic                                        ram_valid,
    output logic                                        ram_we,
    output logic [LOCAL_ADDR_BITS-1:0]                  ram_local_addr,
    output logic [PRI_BITS-1:0]                         ram_pri,
    output logic [DATA_WIDTH-1:0]                       ram_wdata,
    output logic [CORE_ID_BITS-1:0]                     ram_core_id,
    input  logic                                        rsp_valid,
    input  logic [CORE_ID_BITS+PRI_BITS+DATA_WIDTH:0]   rsp_pkt,
    output logic                                        done_valid,
    output logic                                        done_ok,
    output logic [DATA_WIDTH-1:0]                       done_rdata,
    output logic [2:0]                                  done_attempts,
    output logic [CNT_W-1:0]                            fail_cnt
);

    localparam int TMR_W = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                       state, state_n;
    logic                         lat_we;
    logic [LOCAL_ADDR_BITS-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]        lat_wdata;
    logic [PRI_BITS-1:0]          pri_cur;
    logic [2:0]                   attempts;
    logic [TMR_W-1:0]             timer;
    logic [DATA_WIDTH-1:0]        rdata;
    logic                         ok;

    logic [CORE_ID_BITS-1:0]      rsp_cid;
    logic                         rsp_succ;
    logic [DATA_WIDTH-1:0]        rsp_data;
    logic [PRI_BITS-1:0]          unused_rsp_pri;
    logic                         rsp_hit;
    logic                         attempt_fail;
    logic                         retry;
    logic                         busy;

    assign rsp_data       = rsp_pkt[DATA_WIDTH-1:0];
    assign rsp_succ       = rsp_pkt[DATA_WIDTH];
    assign unused_rsp_pri = rsp_pkt[DATA_WIDTH+PRI_BITS:DATA_WIDTH+1];
    assign rsp_cid        = rsp_pkt[CORE_ID_BITS+PRI_BITS+DATA_WIDTH:DATA_WIDTH+PRI_BITS+1];

    // A failed attempt (negative response or timeout) either re-issues or finishes not-ok.
    always_comb begin
        state_n      = state;
        rsp_hit      = 1'b0;
        attempt_fail = 1'b0;
        retry        = 1'b0;
        case (state)
            S_IDLE:  if (req_valid) state_n = S_ISSUE;
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                rsp_hit = rsp_valid && (rsp_cid == CORE_ID_BITS'(CORE_ID));
                if (rsp_hit) begin
                    if (rsp_succ) state_n = S_DONE;
                    else          attempt_fail = 1'b1;
                end else if (timer == TMR_W'(RSP_TIMEOUT - 1)) begin
                    attempt_fail = 1'b1;
                end
                if (attempt_fail) begin
                    if (32'(attempts) <= MAX_RETRY) begin
                        retry   = 1'b1;
                        state_n = S_ISSUE;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            pri_cur   <= '0;
            attempts  <= '0;
            timer     <= '0;
            rdata     <= '0;
            ok        <= 1'b0;
            fail_cnt  <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                pri_cur   <= req_pri;
                attempts  <= 3'd1;
            end
            if (state == S_ISSUE)     timer <= '0;
            else if (state == S_WAIT) timer <= timer + TMR_W'(1);
            if (rsp_hit) rdata <= rsp_data;
            if (attempt_fail && fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
            if (retry) begin
                if (attempts != 3'd7) attempts <= attempts + 3'd1;
                if (pri_cur != '1)    pri_cur  <= pri_cur + PRI_BITS'(1);
            end
            if (state == S_WAIT && state_n == S_DONE) ok <= rsp_hit && rsp_succ;
        end
    end

    assign busy           = (state == S_ISSUE) || (state == S_WAIT);
    assign req_ready      = (state == S_IDLE) && !rst;
    assign ram_valid      = (state == S_ISSUE);
    assign ram_we         = busy && lat_we;
    assign ram_local_addr = busy ? lat_addr : '0;
    assign ram_pri        = busy ? pri_cur : '0;
    assign ram_wdata      = busy ? lat_wdata : '0;
    assign ram_core_id    = CORE_ID_BITS'(CORE_ID);
    assign done_valid     = (state == S_DONE);
    assign done_ok        = (state == S_DONE) && ok;
    assign done_rdata     = (state == S_DONE) ? rdata : '0;
    assign done_attempts  = (state == S_DONE) ? attempts : '0;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Bench for mem_req_initiator: a transaction-level schedule model predicts every RAM pulse
// and completion per cycle for two differently-parameterised instances.
module tb_mem_req_initiator;
    localparam int AW = 8, DW = 16, CIDW = 2;
    localparam int KEYS = 1000000;
    int P_CID[2]    = '{1, 2};
    int P_MAXR[2]   = '{3, 5};
    int P_TO[2]     = '{8, 4};
    int P_PRIMAX[2] = '{7, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            req_valid[2], req_we[2], rsp_valid[2], pk_succ[2];
    logic [AW-1:0]   req_addr[2];
    logic [DW-1:0]   req_wdata[2], pk_data[2];
    logic [2:0]      req_pri[2], pk_pri[2];
    logic [CIDW-1:0] pk_cid[2];
    logic [21:0]     pkt_a;
    logic [20:0]     pkt_b;
    assign pkt_a = {pk_cid[0], pk_pri[0], pk_succ[0], pk_data[0]};
    assign pkt_b = {pk_cid[1], pk_pri[1][1:0], pk_succ[1], pk_data[1]};

    logic ready_a, rv_a, rwe_a, dv_a, dok_a, ready_b, rv_b, rwe_b, dv_b, dok_b;
    logic [AW-1:0] raddr_a, raddr_b;
    logic [2:0] rpri_a, datt_a, datt_b;
    logic [1:0] rpri_b, rcid_a, rcid_b;
    logic [DW-1:0] rwd_a, drd_a, rwd_b, drd_b;
    logic [15:0] fcnt_a, fcnt_b;

    mem_req_initiator #(.CORE_ID(1), .MAX_RETRY(3), .RSP_TIMEOUT(8), .CNT_W(16),
        .LOCAL_ADDR_BITS(AW), .DATA_WIDTH(DW), .PRI_BITS(3), .CORE_ID_BITS(CIDW)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(ready_a),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_pri(req_pri[0]), .ram_valid(rv_a), .ram_we(rwe_a), .ram_local_addr(raddr_a),
        .ram_pri(rpri_a), .ram_wdata(rwd_a), .ram_core_id(rcid_a), .rsp_valid(rsp_valid[0]),
        .rsp_pkt(pkt_a), .done_valid(dv_a), .done_ok(dok_a), .done_rdata(drd_a),
        .done_attempts(datt_a), .fail_cnt(fcnt_a));

    mem_req_initiator #(.CORE_ID(2), .MAX_RETRY(5), .RSP_TIMEOUT(4), .CNT_W(16),
        .LOCAL_ADDR_BITS(AW), .DATA_WIDTH(DW), .PRI_BITS(2), .CORE_ID_BITS(CIDW)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(ready_b),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_pri(req_pri[1][1:0]), .ram_valid(rv_b), .ram_we(rwe_b), .ram_local_addr(raddr_b),
        .ram_pri(rpri_b), .ram_wdata(rwd_b), .ram_core_id(rcid_b), .rsp_valid(rsp_valid[1]),
        .rsp_pkt(pkt_b), .done_valid(dv_b), .done_ok(dok_b), .done_rdata(drd_b),
        .done_attempts(datt_b), .fail_cnt(fcnt_b));

    int n_pass = 0, n_total = 0;
    int o_ready[2], o_rv[2], o_we[2], o_addr[2], o_pri[2], o_wd[2], o_cid[2];
    int o_dv[2], o_ok[2], o_rd[2], o_att[2], o_fc[2];

    // expected pulses / completions and response stimulus, keyed by instance*KEYS+cycle
    int ep_pri[int], ep_we[int], ep_addr[int], ep_wd[int];
    int ed_ok[int], ed_rd[int], ed_att[int], ed_fc[int];
    int rs_cid[int], rs_succ[int], rs_data[int], rs_pri[int];
    int m_fc[2], m_rd[2];
    int pl_d[8], pl_s[8], pl_dat[8], pl_fd[8];
    int obs_pcyc[$], obs_pri[$];
    int obs_dcnt = 0, obs_dcyc = 0, obs_dok = 0, obs_drd = 0, obs_datt = 0, obs_dfc = 0;
    int hs;

    function automatic int key(input int i, input int c);
        return i * KEYS + c;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic void snap();
        o_ready[0] = int'(ready_a); o_rv[0] = int'(rv_a); o_we[0] = int'(rwe_a);
        o_addr[0] = int'(raddr_a); o_pri[0] = int'(rpri_a); o_wd[0] = int'(rwd_a);
        o_cid[0] = int'(rcid_a); o_dv[0] = int'(dv_a); o_ok[0] = int'(dok_a);
        o_rd[0] = int'(drd_a); o_att[0] = int'(datt_a); o_fc[0] = int'(fcnt_a);
        o_ready[1] = int'(ready_b); o_rv[1] = int'(rv_b); o_we[1] = int'(rwe_b);
        o_addr[1] = int'(raddr_b); o_pri[1] = int'(rpri_b); o_wd[1] = int'(rwd_b);
        o_cid[1] = int'(rcid_b); o_dv[1] = int'(dv_b); o_ok[1] = int'(dok_b);
        o_rd[1] = int'(drd_b); o_att[1] = int'(datt_b); o_fc[1] = int'(fcnt_b);
    endfunction

    always @(negedge clk) begin
        snap();
        for (int i = 0; i < 2; i++) begin
            int k;
            k = key(i, cyc);
            chk("ram_core_id", o_cid[i], P_CID[i]);
            if (ep_pri.exists(k)) begin
                chk("ram_valid", o_rv[i], 1);
                chk("ram_pri", o_pri[i], ep_pri[k]);
                chk("ram_we", o_we[i], ep_we[k]);
                chk("ram_local_addr", o_addr[i], ep_addr[k]);
                chk("ram_wdata", o_wd[i], ep_wd[k]);
            end else begin
                chk("ram_valid_quiet", o_rv[i], 0);
            end
            if (ed_ok.exists(k)) begin
                chk("done_valid", o_dv[i], 1);
                chk("done_ok", o_ok[i], ed_ok[k]);
                chk("done_rdata", o_rd[i], ed_rd[k]);
                chk("done_attempts", o_att[i], ed_att[k]);
                chk("fail_cnt", o_fc[i], ed_fc[k]);
                chk("req_ready_done", o_ready[i], 0);
            end else begin
                chk("done_valid_quiet", o_dv[i], 0);
            end
            if (o_rv[i] == 1) begin
                obs_pcyc.push_back(cyc);
                obs_pri.push_back(o_pri[i]);
            end
            if (o_dv[i] == 1) begin
                obs_dcnt++; obs_dcyc = cyc; obs_dok = o_ok[i]; obs_drd = o_rd[i];
                obs_datt = o_att[i]; obs_dfc = o_fc[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
        snap();
    endtask

    task automatic plan_clear();
        for (int k = 0; k < 8; k++) begin
            pl_d[k] = -1; pl_s[k] = 0; pl_dat[k] = 0; pl_fd[k] = -1;
        end
        obs_pcyc.delete();
        obs_pri.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        m_fc[0] = 0; m_fc[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
    endtask

    function automatic int qget(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    // Model: each attempt either gets its planned response d cycles into the wait window
    // or times out after RSP_TIMEOUT wait cycles; failures escalate priority until retries run out.
    task automatic run_txn(input int i, input int we, input int addr, input int wd,
                           input int pri, input int np);
        int n, p, att, pr, dc, ok, nx, d;
        n = cyc; p = n + 1; att = 1; pr = pri; dc = 0; ok = 0;
        hs = n;
        for (int k = 0; k < 16; k++) begin
            d = (k < np) ? pl_d[k] : -1;
            ep_pri[key(i, p)] = pr; ep_we[key(i, p)] = we;
            ep_addr[key(i, p)] = addr; ep_wd[key(i, p)] = wd;
            if (k < np && pl_fd[k] >= 0) begin
                rs_cid[key(i, p + 1 + pl_fd[k])] = (P_CID[i] + 1) % 4;
                rs_succ[key(i, p + 1 + pl_fd[k])] = 1;
                rs_data[key(i, p + 1 + pl_fd[k])] = 16'hdead;
                rs_pri[key(i, p + 1 + pl_fd[k])] = pr;
            end
            if (d >= 0) begin
                rs_cid[key(i, p + 1 + d)] = P_CID[i]; rs_succ[key(i, p + 1 + d)] = pl_s[k];
                rs_data[key(i, p + 1 + d)] = pl_dat[k]; rs_pri[key(i, p + 1 + d)] = pr;
                m_rd[i] = pl_dat[k];
                if (pl_s[k] != 0) begin
                    ok = 1; dc = p + 2 + d;
                    break;
                end
                nx = p + 2 + d;
            end else begin
                nx = p + 1 + P_TO[i];
            end
            if (m_fc[i] < 65535) m_fc[i]++;
            if (att <= P_MAXR[i]) begin
                att++;
                pr = (pr < P_PRIMAX[i]) ? pr + 1 : P_PRIMAX[i];
                p = nx;
            end else begin
                dc = nx;
                break;
            end
        end
        ed_ok[key(i, dc)] = ok; ed_rd[key(i, dc)] = m_rd[i];
        ed_att[key(i, dc)] = (att > 7) ? 7 : att; ed_fc[key(i, dc)] = m_fc[i];

        settle();
        chk("req_ready_idle", o_ready[i], 1);
        req_valid[i] = 1'b1; req_we[i] = we[0]; req_addr[i] = AW'(addr);
        req_wdata[i] = DW'(wd); req_pri[i] = 3'(pri);
        for (int c = n; c <= dc; c++) begin
            int kk;
            kk = key(i, c);
            if (c > n) begin
                req_valid[i] = 1'b0; req_addr[i] = ~AW'(addr); req_wdata[i] = ~DW'(wd);
                req_we[i] = ~we[0];
            end
            if (rs_cid.exists(kk)) begin
                rsp_valid[i] = 1'b1; pk_cid[i] = CIDW'(rs_cid[kk]); pk_succ[i] = (rs_succ[kk] != 0);
                pk_data[i] = DW'(rs_data[kk]); pk_pri[i] = 3'(rs_pri[kk]);
            end else begin
                rsp_valid[i] = 1'b0; pk_cid[i] = '0; pk_succ[i] = 1'b0; pk_data[i] = '0;
                pk_pri[i] = '0;
            end
            tick();
        end
        rsp_valid[i] = 1'b0; req_valid[i] = 1'b0;
    endtask

    initial begin
        int dcnt0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
            req_pri[i] = '0; rsp_valid[i] = 1'b0; pk_cid[i] = '0; pk_pri[i] = '0;
            pk_succ[i] = 1'b0; pk_data[i] = '0;
        end
        tick(); tick();
        do_reset();
        settle();
        for (int i = 0; i < 2; i++) begin
            chk("reset_req_ready", o_ready[i], 1);
            chk("reset_ram_valid", o_rv[i], 0);
            chk("reset_ram_addr", o_addr[i], 0);
            chk("reset_done_valid", o_dv[i], 0);
            chk("reset_fail_cnt", o_fc[i], 0);
        end
        tick();

        // basic read, best-case latency
        plan_clear(); pl_d[0] = 0; pl_s[0] = 1; pl_dat[0] = 'h06;
        run_txn(0, 0, 5, 0, 0, 1);
        chk("t1_pulses", obs_pcyc.size(), 1);
        chk("t1_pulse_lat", qget(obs_pcyc, 0) - hs, 1);
        chk("t1_done_lat", obs_dcyc - hs, 3);
        chk("t1_ok", obs_dok, 1); chk("t1_rdata", obs_drd, 'h06); chk("t1_att", obs_datt, 1);

        // write, one negative response then success
        do_reset();
        plan_clear(); pl_d[0] = 0; pl_s[0] = 0; pl_dat[0] = 'h11;
        pl_d[1] = 1; pl_s[1] = 1; pl_dat[1] = 'h22;
        run_txn(0, 1, 3, 'hBEEF, 1, 2);
        chk("t2_pulses", obs_pcyc.size(), 2);
        chk("t2_pri0", qget(obs_pri, 0), 1); chk("t2_pri1", qget(obs_pri, 1), 2);
        chk("t2_ok", obs_dok, 1); chk("t2_att", obs_datt, 2); chk("t2_fcnt", obs_dfc, 1);

        // retries exhausted
        do_reset();
        plan_clear();
        for (int k = 0; k < 4; k++) begin
            pl_d[k] = 2; pl_s[k] = 0; pl_dat[k] = 'h30 + k;
        end
        run_txn(0, 0, 9, 0, 0, 4);
        chk("t3_pulses", obs_pcyc.size(), 4);
        for (int k = 0; k < 4; k++) chk("t3_pri", qget(obs_pri, k), k);
        chk("t3_ok", obs_dok, 0); chk("t3_att", obs_datt, 4); chk("t3_fcnt", obs_dfc, 4);
        chk("t3_rdata", obs_drd, 'h33);

        // timeouts, then response on the exact timeout cycle
        plan_clear(); pl_d[2] = 7; pl_s[2] = 1; pl_dat[2] = 'h44;
        run_txn(0, 0, 12, 0, 0, 3);
        chk("t4_pulses", obs_pcyc.size(), 3);
        chk("t4_gap1", qget(obs_pcyc, 1) - qget(obs_pcyc, 0), 9);
        chk("t4_gap2", qget(obs_pcyc, 2) - qget(obs_pcyc, 1), 9);
        chk("t4_done_gap", obs_dcyc - qget(obs_pcyc, 2), 9);
        chk("t4_ok", obs_dok, 1); chk("t4_att", obs_datt, 3); chk("t4_fcnt", obs_dfc, 6);

        // stray response while idle, then foreign core_id during wait
        dcnt0 = obs_dcnt;
        rsp_valid[0] = 1'b1; pk_cid[0] = 2'd1; pk_succ[0] = 1'b1; pk_data[0] = 16'h00AB;
        tick();
        rsp_valid[0] = 1'b0;
        tick();
        chk("t5_idle_rsp_dropped", obs_dcnt, dcnt0);
        plan_clear(); pl_fd[0] = 1; pl_d[0] = 3; pl_s[0] = 1; pl_dat[0] = 'h55;
        run_txn(0, 1, 20, 'h0F0F, 2, 1);
        chk("t5_pulses", obs_pcyc.size(), 1);
        chk("t5_ok", obs_dok, 1); chk("t5_rdata", obs_drd, 'h55); chk("t5_att", obs_datt, 1);
        chk("t5_done_lat", obs_dcyc - hs, 6);

        // reset in WAIT, then a stale response
        plan_clear();
        dcnt0 = obs_dcnt;
        hs = cyc;
        ep_pri[key(0, hs + 1)] = 2; ep_we[key(0, hs + 1)] = 1;
        ep_addr[key(0, hs + 1)] = 'h44; ep_wd[key(0, hs + 1)] = 'h1234;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h44;
        req_wdata[0] = 16'h1234; req_pri[0] = 3'd2;
        tick();
        req_valid[0] = 1'b0; req_addr[0] = '0; req_wdata[0] = '0; req_we[0] = 1'b0;
        tick();
        settle();
        chk("t6_wait_addr_held", o_addr[0], 'h44);
        chk("t6_wait_we_held", o_we[0], 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_fc[0] = 0; m_fc[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
        rsp_valid[0] = 1'b1; pk_cid[0] = 2'd1; pk_succ[0] = 1'b1; pk_data[0] = 16'h0077;
        settle();
        chk("t6_ready", o_ready[0], 1); chk("t6_ram_valid", o_rv[0], 0);
        chk("t6_ram_we", o_we[0], 0); chk("t6_ram_addr", o_addr[0], 0);
        chk("t6_ram_pri", o_pri[0], 0); chk("t6_ram_wdata", o_wd[0], 0);
        chk("t6_done_ok", o_ok[0], 0); chk("t6_done_rdata", o_rd[0], 0);
        chk("t6_done_att", o_att[0], 0); chk("t6_fail_cnt", o_fc[0], 0);
        tick();
        rsp_valid[0] = 1'b0;
        tick(); tick();
        chk("t6_no_done", obs_dcnt, dcnt0);

        plan_clear(); pl_d[0] = 1; pl_s[0] = 1; pl_dat[0] = 'h99;
        run_txn(0, 0, 7, 0, 0, 1);
        chk("t6_next_ok", obs_dok, 1); chk("t6_next_rdata", obs_drd, 'h99);
        chk("t6_next_lat", obs_dcyc - hs, 4);

        // priority saturation on the 2-bit-priority instance
        plan_clear();
        for (int k = 0; k < 6; k++) begin
            pl_d[k] = 0; pl_s[k] = 0; pl_dat[k] = 'h60 + k;
        end
        run_txn(1, 0, 'h10, 0, 1, 6);
        chk("t6b_pulses", obs_pcyc.size(), 6);
        chk("t6b_pri0", qget(obs_pri, 0), 1); chk("t6b_pri1", qget(obs_pri, 1), 2);
        for (int k = 2; k < 6; k++) chk("t6b_pri_sat", qget(obs_pri, k), 3);
        chk("t6b_ok", obs_dok, 0); chk("t6b_att", obs_datt, 6); chk("t6b_fcnt", obs_dfc, 6);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
